// File: rtl/pulse_loop_pkg.sv
// Shared types and timing helpers for the multi-channel pulse loop generator.
package pulse_loop_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pl_state_e;

  // A zero HIGH still occupies one silent cycle so the period keeps running.
  function automatic logic [31:0] high_len(input logic [31:0] high);
    return (high == 32'd0) ? 32'd1 : high;
  endfunction

  // LOW lasts TOTAL minus the effective HIGH length, never less than one cycle.
  function automatic logic [31:0] low_len(input logic [31:0] total, input logic [31:0] high);
    logic [31:0] h;
    h = high_len(high);
    return (total > h) ? (total - h) : 32'd1;
  endfunction

endpackage

// File: rtl/pulse_loop_ch.sv
// One pulse loop channel: delay, then HIGH/LOW periods in burst or continuous mode.
module pulse_loop_ch
  import pulse_loop_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] first,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] num,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  pl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             hon_q, hon_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    hon_d   = hon_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            high_d = CNT_W'(high_len(32'(high)));
            low_d  = CNT_W'(low_len(32'(total), 32'(high)));
            num_d  = num;
            hon_d  = (high != '0);
            pcnt_d = '0;
            if (first == '0) begin
              state_d = ST_HIGH;
              cnt_d   = high_d;
              pcnt_d  = CNT_W'(1);
            end else begin
              state_d = ST_DELAY;
              cnt_d   = first;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_HIGH;
            cnt_d   = high_q;
            pcnt_d  = pcnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_LOW;
            cnt_d   = low_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (cnt_q == CNT_W'(1)) begin
            // Pulse count is only consulted in burst mode, so its wrap is harmless.
            if ((num_q == '0) || (pcnt_q < num_q)) begin
              state_d = ST_HIGH;
              cnt_d   = high_q;
              pcnt_d  = pcnt_q + CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    pulse_d = (state_d == ST_HIGH) && hon_d;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      hon_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      hon_q   <= hon_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: rtl/pulse_loop_gen_mc.sv
// Multi-channel programmable pulse loop generator: bus slicing and legacy auto-start.
module pulse_loop_gen_mc
  import pulse_loop_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter bit          AUTO_START = 1'b0,
  parameter int unsigned DEF_FIRST  = 1,
  parameter int unsigned DEF_HIGH   = 1,
  parameter int unsigned DEF_TOTAL  = 2
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [CH_NUM-1:0]       START_I,
  input  logic [CH_NUM-1:0]       STOP_I,
  input  logic [CH_NUM*CNT_W-1:0] FIRST_I,
  input  logic [CH_NUM*CNT_W-1:0] HIGH_I,
  input  logic [CH_NUM*CNT_W-1:0] TOTAL_I,
  input  logic [CH_NUM*CNT_W-1:0] NUM_I,
  output logic [CH_NUM-1:0]       PULSE_O,
  output logic [CH_NUM-1:0]       BUSY_O,
  output logic [CH_NUM-1:0]       DONE_O
);

  logic boot_q, boot_d;
  logic auto_go;

  // High only in the first cycle after reset release.
  always_comb boot_d = RST_I;

  always_ff @(posedge CLK_I) boot_q <= boot_d;

  assign auto_go = AUTO_START && boot_q;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic             start_w;
    logic [CNT_W-1:0] first_w, high_w, total_w, num_w;

    assign start_w = START_I[c] | auto_go;
    assign first_w = auto_go ? CNT_W'(DEF_FIRST) : FIRST_I[c*CNT_W +: CNT_W];
    assign high_w  = auto_go ? CNT_W'(DEF_HIGH)  : HIGH_I[c*CNT_W +: CNT_W];
    assign total_w = auto_go ? CNT_W'(DEF_TOTAL) : TOTAL_I[c*CNT_W +: CNT_W];
    assign num_w   = auto_go ? '0                : NUM_I[c*CNT_W +: CNT_W];

    pulse_loop_ch #(.CNT_W(CNT_W)) u_ch (
      .clk   (CLK_I),
      .rst   (RST_I),
      .start (start_w),
      .stop  (STOP_I[c]),
      .first (first_w),
      .high  (high_w),
      .total (total_w),
      .num   (num_w),
      .pulse (PULSE_O[c]),
      .busy  (BUSY_O[c]),
      .done  (DONE_O[c])
    );
  end

endmodule

// File: tb/tb_pulse_loop_gen_mc.sv
// Scoreboard bench: a waveform-level channel model predicts every output cycle of
// a normal and an auto-start instance driven with the same stimulus.
module tb_pulse_loop_gen_mc;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned HN = 8192;

  typedef struct packed {
    logic [CH-1:0] p0, b0, d0;
    logic [CH-1:0] p1, b1, d1;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_v;
  logic [CH-1:0]   st_v, sp_v;
  logic [CH*W-1:0] first_b, high_b, total_b, num_b;
  logic [CH-1:0]   pulse0, busy0, done0, pulse1, busy1, done1;

  int unsigned cf [CH];
  int unsigned chh[CH];
  int unsigned ct [CH];
  int unsigned cn [CH];

  // Model state per (instance, channel): future outputs as {pulse,busy,done}.
  logic [2:0]  chq [2*CH][$];
  logic [2:0]  cur [2*CH];
  bit          cont[2*CH];
  int unsigned m_hi[2*CH];
  int unsigned m_tot[2*CH];
  bit          auto_pend;

  exp_t        scb[$];
  exp_t        mon_e;
  int          checks, failures;
  int          scyc, mcnt;
  logic [CH-1:0] h_p[HN], h_b[HN], h_d[HN], ha_p[HN], ha_b[HN];

  always #5 clk = ~clk;

  pulse_loop_gen_mc #(.CH_NUM(CH), .CNT_W(W), .AUTO_START(1'b0)) dut (
    .CLK_I(clk), .RST_I(rst_v), .START_I(st_v), .STOP_I(sp_v),
    .FIRST_I(first_b), .HIGH_I(high_b), .TOTAL_I(total_b), .NUM_I(num_b),
    .PULSE_O(pulse0), .BUSY_O(busy0), .DONE_O(done0)
  );

  pulse_loop_gen_mc #(.CH_NUM(CH), .CNT_W(W), .AUTO_START(1'b1),
                      .DEF_FIRST(1), .DEF_HIGH(1), .DEF_TOTAL(2)) dut_a (
    .CLK_I(clk), .RST_I(rst_v), .START_I(st_v), .STOP_I(sp_v),
    .FIRST_I(first_b), .HIGH_I(high_b), .TOTAL_I(total_b), .NUM_I(num_b),
    .PULSE_O(pulse1), .BUSY_O(busy1), .DONE_O(done1)
  );

  // One period of the waveform: HIGH (at least one cycle), then LOW (at least one).
  task automatic push_period(input int i);
    int unsigned he, lo;
    he = (m_hi[i] == 0) ? 1 : m_hi[i];
    lo = (m_tot[i] > he) ? m_tot[i] - he : 1;
    repeat (he) chq[i].push_back({(m_hi[i] != 0), 1'b1, 1'b0});
    repeat (lo) chq[i].push_back(3'b010);
  endtask

  task automatic model_start(input int i, input int unsigned f, input int unsigned h,
                             input int unsigned t, input int unsigned n);
    m_hi[i]  = h;
    m_tot[i] = t;
    cont[i]  = (n == 0);
    repeat (f) chq[i].push_back(3'b010);
    if (n != 0) begin
      repeat (n) push_period(i);
      chq[i].push_back(3'b001);
    end
  endtask

  task automatic model_cycle(input int i, input bit rs, input bit st, input bit sp,
                             input int unsigned f, input int unsigned h,
                             input int unsigned t, input int unsigned n);
    if (rs) begin
      chq[i].delete();
      cont[i] = 1'b0;
    end else if (sp) begin
      if (cur[i][1]) begin
        chq[i].delete();
        cont[i] = 1'b0;
      end
    end else if (st && !cur[i][1]) begin
      model_start(i, f, h, t, n);
    end
    if (!rs && cont[i] && chq[i].size() == 0) push_period(i);
    cur[i] = (chq[i].size() != 0) ? chq[i].pop_front() : 3'b000;
  endtask

  // Drive this cycle's inputs, predict next-cycle outputs, advance to next negedge.
  task automatic tick();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      first_b[c*W +: W] = W'(cf[c]);
      high_b[c*W +: W]  = W'(chh[c]);
      total_b[c*W +: W] = W'(ct[c]);
      num_b[c*W +: W]   = W'(cn[c]);
    end
    for (int c = 0; c < CH; c++) begin
      model_cycle(c, rst_v, st_v[c], sp_v[c], cf[c], chh[c], ct[c], cn[c]);
      if (auto_pend)
        model_cycle(CH + c, rst_v, 1'b1, sp_v[c], 1, 1, 2, 0);
      else
        model_cycle(CH + c, rst_v, st_v[c], sp_v[c], cf[c], chh[c], ct[c], cn[c]);
    end
    auto_pend = rst_v;
    for (int c = 0; c < CH; c++) begin
      {e.p0[c], e.b0[c], e.d0[c]} = cur[c];
      {e.p1[c], e.b1[c], e.d1[c]} = cur[CH + c];
    end
    scb.push_back(e);
    scyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_cfg(input int c, input int unsigned f, input int unsigned h,
                         input int unsigned t, input int unsigned n);
    cf[c] = f; chh[c] = h; ct[c] = t; cn[c] = n;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp, input int cy);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cy, got, exp);
    end
  endtask

  // Fixed burst FIRST=3 HIGH=2 TOTAL=5 NUM=2 on channel 0 started in cycle s0.
  task automatic check_burst(input int s0);
    for (int d = 1; d <= 15; d++) begin
      chk("burst_pulse", h_p[s0+d][0], (d == 4 || d == 5 || d == 9 || d == 10), s0 + d);
      chk("burst_busy",  h_b[s0+d][0], (d >= 1 && d <= 13), s0 + d);
      chk("burst_done",  h_d[s0+d][0], (d == 14), s0 + d);
    end
  endtask

  // Monitor: compares each DUT output cycle against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() != 0) begin
        mon_e = scb.pop_front();
        mcnt++;
        if (mcnt < HN) begin
          h_p[mcnt] = pulse0; h_b[mcnt] = busy0; h_d[mcnt] = done0;
          ha_p[mcnt] = pulse1; ha_b[mcnt] = busy1;
        end
        checks++;
        if ({pulse0, busy0, done0} !== {mon_e.p0, mon_e.b0, mon_e.d0}) begin
          failures++;
          $display("FAIL scb_main cyc=%0d got p=%b b=%b d=%b exp p=%b b=%b d=%b",
                   mcnt, pulse0, busy0, done0, mon_e.p0, mon_e.b0, mon_e.d0);
        end
        checks++;
        if ({pulse1, busy1, done1} !== {mon_e.p1, mon_e.b1, mon_e.d1}) begin
          failures++;
          $display("FAIL scb_auto cyc=%0d got p=%b b=%b d=%b exp p=%b b=%b d=%b",
                   mcnt, pulse1, busy1, done1, mon_e.p1, mon_e.b1, mon_e.d1);
        end
      end
    end
  end

  initial begin
    int s0, r0, k;
    bit hold[CH];
    checks = 0; failures = 0; scyc = 0; mcnt = 0; auto_pend = 1'b0;
    rst_v = 1'b1; st_v = '0; sp_v = '0;
    first_b = '0; high_b = '0; total_b = '0; num_b = '0;
    for (int i = 0; i < 2*CH; i++) begin
      cur[i] = 3'b000; cont[i] = 1'b0; m_hi[i] = 0; m_tot[i] = 0;
    end
    for (int c = 0; c < CH; c++) begin
      set_cfg(c, 0, 0, 0, 0);
      hold[c] = 1'b0;
    end

    // Reset through cycle 3, auto-start instance must then toggle 0,1,0,1.
    run(4);
    rst_v = 1'b0;
    r0 = scyc;
    run(10);
    for (int d = 1; d <= 8; d++) begin
      chk("auto_pulse", ha_p[r0+d][0], (d >= 2 && d % 2 == 0), r0 + d);
      chk("auto_busy",  ha_b[r0+d][3], 1'b1, r0 + d);
    end

    // Burst on channel 0.
    set_cfg(0, 3, 2, 5, 2);
    s0 = scyc; st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
    run(16);
    check_burst(s0);

    // Continuous channel 1, stopped during a HIGH cycle.
    set_cfg(1, 2, 1, 4, 0);
    st_v[1] = 1'b1; tick(); st_v[1] = 1'b0;
    run(6);
    k = 0;
    while (!cur[1][2] && k < 20) begin tick(); k++; end
    chk("stop_reach_high", cur[1][2], 1'b1, scyc);
    sp_v[1] = 1'b1; tick(); sp_v[1] = 1'b0;
    run(6);

    // Degenerate: TOTAL below HIGH, single pulse, zero delay.
    set_cfg(0, 0, 3, 2, 1);
    st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
    run(8);

    // Busy channel ignores a new start; a neighbour starts in the same cycle.
    set_cfg(2, 2, 2, 3, 3);
    set_cfg(3, 1, 1, 3, 2);
    st_v[3:2] = 2'b11; tick(); st_v[3:2] = 2'b00;
    run(3);
    set_cfg(2, 5, 4, 9, 1);
    st_v[2] = 1'b1; tick(); st_v[2] = 1'b0;
    run(14);

    // Reset mid-burst on all channels, then the first burst again.
    for (int c = 0; c < CH; c++) set_cfg(c, 1, 2, 4, 3);
    st_v = '1; tick(); st_v = '0;
    run(5);
    rst_v = 1'b1; tick(); rst_v = 1'b0;
    run(3);
    set_cfg(0, 3, 2, 5, 2);
    s0 = scyc; st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
    run(16);
    check_burst(s0);

    // Randomized traffic including held starts, stops and rare resets.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) == 0) hold[c] = !hold[c];
        set_cfg(c, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 7), $urandom_range(0, 3));
        st_v[c] = hold[c] || ($urandom_range(0, 7) == 0);
        sp_v[c] = ($urandom_range(0, 59) == 0);
      end
      rst_v = ($urandom_range(0, 799) == 0);
      tick();
    end
    st_v = '0; sp_v = '0; rst_v = 1'b0;
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_loop_gen_mc.md
Name: pulse_loop_gen_mc

Overview:
Multi-channel, run-time-programmable successor to the fixed-timing single pulse loop generator. Each channel produces a periodic pulse train after a first delay, in either burst (N pulses) or continuous mode. Each channel is started and stopped independently and reports busy/done status. The block sits beside timer/sequencing logic and drives strobes, test triggers and periodic kicks.

Parameters:
CH_NUM, 4, number of independent channels
CNT_W, 16, width of all cycle-count fields (first delay, high, total, burst count)
AUTO_START, 0, 1 = every channel starts continuous mode with default timing on the first cycle after reset release (legacy-compatible mode)
DEF_FIRST, 1, default first-delay cycles used by AUTO_START
DEF_HIGH, 1, default high cycles used by AUTO_START
DEF_TOTAL, 2, default period cycles used by AUTO_START

Ports:
CLK_I  in  1  single clock domain
RST_I  in  1  synchronous reset, active-high
START_I  in  CH_NUM  per-channel start strobe, level sampled each cycle
STOP_I  in  CH_NUM  per-channel abort strobe
FIRST_I  in  CH_NUM*CNT_W  first-delay cycles; channel c uses slice [c*CNT_W +: CNT_W]
HIGH_I  in  CH_NUM*CNT_W  pulse-high cycles per period
TOTAL_I  in  CH_NUM*CNT_W  period cycles
NUM_I  in  CH_NUM*CNT_W  pulse count; 0 = continuous
PULSE_O  out  CH_NUM  registered pulse output
BUSY_O  out  CH_NUM  channel running
DONE_O  out  CH_NUM  one-cycle pulse when a burst completes

Behaviour:
- Reset: PULSE_O=0, BUSY_O=0, DONE_O=0, all counters 0, all channels IDLE. If AUTO_START=1, every channel leaves reset as if START_I were sampled in the first cycle after RST_I falls, using DEF_* values and NUM=0.
- Reset mid-operation: returns every channel to IDLE on the next edge. No DONE_O is emitted.
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW. All outputs are registered.
- IDLE + START_I=1 in cycle k:
  - Latch FIRST, HIGH, TOTAL, NUM.
  - BUSY_O=1 from cycle k+1.
  - DELAY occupies cycles k+1..k+FIRST. If FIRST=0, go directly to HIGH at k+1.
- HIGH: PULSE_O=1 for HIGH cycles, then go to LOW.
- LOW: PULSE_O=0 for TOTAL-HIGH cycles. At the end of LOW:
  - Continuous mode, or pulses issued < NUM: go to HIGH.
  - Otherwise: go to IDLE, BUSY_O=0 and DONE_O=1 in the same cycle (one cycle only).
- Degenerate timing, resolved at latch time:
  - HIGH=0: the pulse never asserts, but timing and burst counting still run.
  - TOTAL<=HIGH: the LOW phase lasts exactly 1 cycle.
- Latched config is frozen while BUSY. Input changes take effect only on the next start.
- START_I while BUSY is ignored. START_I held high re-triggers the channel in the cycle DONE_O fires, so BUSY_O drops for that single cycle.
- STOP_I has priority over START_I. Any state goes to IDLE next cycle with PULSE_O=0, BUSY_O=0 and no DONE_O. STOP_I in IDLE has no effect.
- Burst pulse counter is CNT_W bits and is never compared in continuous mode, so wrap-around is harmless.
- Phase counter counts down to 1 and reloads. No count ever exceeds its CNT_W field.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Shared package pulse_loop_pkg:
  - FSM state enum/localparams: ST_IDLE, ST_DELAY, ST_HIGH, ST_LOW.
  - CNT_W default.
  - Helper function for the degenerate-LOW length computation.
- Sub-module pulse_loop_ch: one channel FSM with scalar ports, instantiated CH_NUM times in a generate loop. The top level only slices buses and maps AUTO_START/DEF_* values.

Test Plan:
- Ch0: FIRST=3, HIGH=2, TOTAL=5, NUM=2, START_I high in cycle 10 -> PULSE_O[0] high in cycles 14-15 and 19-20; BUSY_O[0] high 11-23; DONE_O[0] high in cycle 24 only.
- AUTO_START=1 with defaults 1/1/2, RST_I released after cycle 3 -> PULSE_O toggles 0,1,0,1 continuously starting cycle 5; BUSY=1; DONE_O never fires.
- Ch1 continuous (NUM=0), HIGH=1, TOTAL=4, STOP_I pulsed during a HIGH cycle -> PULSE_O[1]=0 and BUSY_O[1]=0 the next cycle; DONE_O stays 0.
- Degenerate case: FIRST=0, HIGH=3, TOTAL=2, NUM=1 -> PULSE_O high cycles k+1..k+3, one LOW cycle, DONE_O at k+5.
- Ch2 busy, START_I re-pulsed with new config -> waveform unchanged. Ch3 started in the same cycle with different timing -> both channels match their independent expected waveforms.
- RST_I asserted mid-burst on all channels -> every output 0 next cycle; no DONE_O; a fresh START_I then reproduces the first scenario exactly.
